muldiv_issue_ctrl: RTL and testbench

- Request/response front-end for the iterative 64-bit multiply/divide unit.
- Accepts an operation over a valid/ready request channel, holds the unit's operands stable and pulses its start, then waits for its ready.
- Captures the 129-bit result and splits it into two 64-bit response words, delivered over a valid/ready response channel.
- Divide-by-zero is short-circuited without starting the unit. A watchdog counter bounds the wait for the unit.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_issue_ctrl_if.sv | 49 ++++
 rtl/muldiv_rsp_split.sv | 27 ++
 rtl/muldiv_issue_ctrl.sv | 104 ++++++++++
 tb/tb_muldiv_issue_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the multiply/divide issue controller.
// Operation encoding, controller state and operand/result layout defaults.
package muldiv_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int DW_DEF      = 64;
    localparam int REM_LSB_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_issue_ctrl_if.sv
// Request, unit and response signals of the multiply/divide issue controller.
// The slave modport is the controller; master is the requester/unit side.
interface muldiv_issue_ctrl_if
    import muldiv_pkg::*;
#(
    parameter int DW = DW_DEF
);
    // Both channels are strict valid/ready: a transfer happens on a clock edge
    // where valid and ready are both 1; a raised valid and its payload hold
    // until that edge, and valid never waits on ready.
    logic            req_valid;
    logic            req_ready;
    logic            req_op;
    logic [DW-1:0]   req_a;
    logic [DW-1:0]   req_b;

    logic [DW-1:0]   core_a;
    logic [DW-1:0]   core_b;
    logic            core_m_d;
    logic            core_start;
    logic [2*DW:0]   core_result;
    logic            core_ready;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_hi;
    logic [DW-1:0]   rsp_lo;
    logic            rsp_dz;
    logic            rsp_timeout;

    modport master (
        output req_valid, req_op, req_a, req_b,
        output core_result, core_ready,
        output rsp_ready,
        input  req_ready,
        input  core_a, core_b, core_m_d, core_start,
        input  rsp_valid, rsp_hi, rsp_lo, rsp_dz, rsp_timeout
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        input  core_result, core_ready,
        input  rsp_ready,
        output req_ready,
        output core_a, core_b, core_m_d, core_start,
        output rsp_valid, rsp_hi, rsp_lo, rsp_dz, rsp_timeout
    );

endinterface

// File: rtl/muldiv_rsp_split.sv
// Splits the unit's wide result into the two response words for the current op.
// The low word is the product low half or the quotient; both sit at bit 0.
module muldiv_rsp_split
    import muldiv_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int REM_LSB = REM_LSB_DEF
) (
    input  logic          op,
    input  logic [2*DW:0] result,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo
);

    // The top result bit carries nothing the response needs.
    logic unused_msb;
    assign unused_msb = result[2*DW];

    always_comb begin
        lo = result[DW-1:0];
        hi = result[2*DW-1:DW];
        if (op == OP_DIV) begin
            hi = result[REM_LSB +: DW];
        end
    end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Front-end FSM for the iterative multiply/divide unit: accept, start, wait
// (bounded by a watchdog), then hold the response until it is taken.
module muldiv_issue_ctrl
    import muldiv_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 200,
    parameter int REM_LSB = REM_LSB_DEF
) (
    input  logic               clk,
    input  logic               reset,
    muldiv_issue_ctrl_if.slave bus,
    output state_t             state
);

    localparam int            CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;
    logic [DW-1:0] split_hi;
    logic [DW-1:0] split_lo;

    muldiv_rsp_split #(
        .DW      (DW),
        .REM_LSB (REM_LSB)
    ) u_split (
        .op     (bus.core_m_d),
        .result (bus.core_result),
        .hi     (split_hi),
        .lo     (split_lo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.req_ready   <= 1'b0;
            bus.core_a      <= '0;
            bus.core_b      <= '0;
            bus.core_m_d    <= 1'b0;
            bus.core_start  <= 1'b0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_hi      <= '0;
            bus.rsp_lo      <= '0;
            bus.rsp_dz      <= 1'b0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            bus.core_start <= 1'b0;
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        bus.core_m_d  <= bus.req_op;
                        bus.core_a    <= bus.req_a;
                        bus.core_b    <= bus.req_b;
                        if (bus.req_op == OP_DIV && bus.req_b == '0) begin
                            state         <= DONE;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_lo    <= '1;
                            bus.rsp_hi    <= bus.req_a;
                            bus.rsp_dz    <= 1'b1;
                        end else begin
                            state          <= ISSUE;
                            bus.core_start <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // cnt == 0 marks the first WAIT cycle, where ready may be stale.
                    if (cnt != '0 && bus.core_ready) begin
                        state         <= DONE;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_hi    <= split_hi;
                        bus.rsp_lo    <= split_lo;
                    end else if (cnt == CNT_LAST) begin
                        state           <= DONE;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_hi      <= '0;
                        bus.rsp_lo      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        state           <= IDLE;
                        bus.req_ready   <= 1'b1;
                        bus.rsp_valid   <= 1'b0;
                        bus.rsp_dz      <= 1'b0;
                        bus.rsp_timeout <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed bench for muldiv_issue_ctrl with a behavioural model of the unit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_muldiv_issue_ctrl;
  import muldiv_pkg::*;

  localparam int DW         = 64;
  localparam int TB_TIMEOUT = 80;
  localparam int REM_LSB    = 64;

  logic clk = 1'b0;
  logic reset = 1'b0;
  state_t state;

  int n_checks = 0;
  int n_pass   = 0;

  // unit model configuration
  int             m_lat    = 1;
  bit             m_stale  = 1'b0;
  logic [2*DW:0]  m_result = '0;
  int             m_cnt;
  bit             m_busy;

  muldiv_issue_ctrl_if #(.DW(DW)) bus ();

  muldiv_issue_ctrl #(
    .DW      (DW),
    .TIMEOUT (TB_TIMEOUT),
    .REM_LSB (REM_LSB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (state)
  );

  always #5 clk = ~clk;

  // unit model: drops ready on start (unless modelling a stale ready),
  // raises ready with the result in the m_lat-th WAIT cycle
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0;
      m_cnt = 0;
      bus.core_ready = 1'b1;
      bus.core_result = '0;
    end else if (bus.core_start) begin
      m_busy = 1'b1;
      m_cnt = 0;
      if (!m_stale) bus.core_ready = 1'b0;
    end else if (m_busy) begin
      m_cnt++;
      if (m_stale && m_cnt == 2) bus.core_ready = 1'b0;
      if (m_cnt == m_lat) begin
        bus.core_ready = 1'b1;
        bus.core_result = m_result;
        m_busy = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_watchdog: got no finish expected finish");
    $fatal(1, "bench watchdog expired");
  end

  // driver tasks
  task automatic issue(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max_cyc, output int lat, output int starts);
    lat = -1;
    starts = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (bus.core_start) starts++;
      if (bus.rsp_valid) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.req_ready, bus.core_start, bus.core_m_d, bus.rsp_valid, bus.rsp_dz, bus.rsp_timeout} !== 6'b0)
      $display("FAIL reset_flags: got %b expected 000000",
               {bus.req_ready, bus.core_start, bus.core_m_d, bus.rsp_valid, bus.rsp_dz, bus.rsp_timeout});
    else n_pass++;
    n_checks++;
    if ({bus.core_a, bus.core_b, bus.rsp_hi, bus.rsp_lo} !== '0)
      $display("FAIL reset_data: got %0h expected 0", {bus.core_a, bus.core_b, bus.rsp_hi, bus.rsp_lo});
    else n_pass++;
    n_checks++;
    if (state !== IDLE) $display("FAIL reset_state: got %0d expected %0d", state, IDLE);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", bus.req_ready);
    else n_pass++;
  endtask

  task automatic test_multiply();
    int lat, starts;
    m_stale = 1'b0;
    m_lat = 66;
    m_result = 129'd15;
    issue(OP_MUL, 64'd3, 64'd5);
    wait_rsp(200, lat, starts);
    n_checks++;
    if (lat !== 68) $display("FAIL mul_latency: got %0d expected 68", lat);
    else n_pass++;
    n_checks++;
    if (starts !== 1) $display("FAIL mul_start_pulses: got %0d expected 1", starts);
    else n_pass++;
    n_checks++;
    if (bus.rsp_hi !== 64'd0 || bus.rsp_lo !== 64'd15)
      $display("FAIL mul_data: got %0h_%0h expected 0_f", bus.rsp_hi, bus.rsp_lo);
    else n_pass++;
    n_checks++;
    if (bus.rsp_dz !== 1'b0 || bus.rsp_timeout !== 1'b0)
      $display("FAIL mul_flags: got dz=%b to=%b expected dz=0 to=0", bus.rsp_dz, bus.rsp_timeout);
    else n_pass++;
    n_checks++;
    if (bus.core_a !== 64'd3 || bus.core_b !== 64'd5 || bus.core_m_d !== OP_MUL)
      $display("FAIL mul_operands: got a=%0h b=%0h md=%b expected a=3 b=5 md=0",
               bus.core_a, bus.core_b, bus.core_m_d);
    else n_pass++;
    take_rsp();
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || state !== IDLE)
      $display("FAIL mul_release: got valid=%b ready=%b state=%0d expected valid=0 ready=1 state=0",
               bus.rsp_valid, bus.req_ready, state);
    else n_pass++;
  endtask

  task automatic test_divide();
    int lat, starts;
    m_stale = 1'b0;
    m_lat = 5;
    m_result = {1'b0, 64'd2, 64'd14};
    issue(OP_DIV, 64'd100, 64'd7);
    wait_rsp(50, lat, starts);
    n_checks++;
    if (lat !== 7) $display("FAIL div_latency: got %0d expected 7", lat);
    else n_pass++;
    n_checks++;
    if (bus.rsp_hi !== 64'd2 || bus.rsp_lo !== 64'd14 || bus.rsp_dz !== 1'b0)
      $display("FAIL div_data: got hi=%0h lo=%0h dz=%b expected hi=2 lo=e dz=0",
               bus.rsp_hi, bus.rsp_lo, bus.rsp_dz);
    else n_pass++;
    n_checks++;
    if (bus.core_m_d !== OP_DIV) $display("FAIL div_mode: got %b expected 1", bus.core_m_d);
    else n_pass++;
    take_rsp();
  endtask

  task automatic test_div_zero();
    int lat, starts;
    issue(OP_DIV, 64'h1234, 64'd0);
    wait_rsp(10, lat, starts);
    n_checks++;
    if (lat !== 1) $display("FAIL dz_latency: got %0d expected 1", lat);
    else n_pass++;
    n_checks++;
    if (starts !== 0) $display("FAIL dz_no_start: got %0d expected 0", starts);
    else n_pass++;
    n_checks++;
    if (bus.rsp_lo !== 64'hFFFF_FFFF_FFFF_FFFF || bus.rsp_hi !== 64'h1234 || bus.rsp_dz !== 1'b1)
      $display("FAIL dz_data: got hi=%0h lo=%0h dz=%b expected hi=1234 lo=ffffffffffffffff dz=1",
               bus.rsp_hi, bus.rsp_lo, bus.rsp_dz);
    else n_pass++;
    n_checks++;
    if (state !== DONE) $display("FAIL dz_state: got %0d expected %0d", state, DONE);
    else n_pass++;
    take_rsp();
    n_checks++;
    if (bus.rsp_dz !== 1'b0) $display("FAIL dz_clear: got %b expected 0", bus.rsp_dz);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int lat, starts;
    m_stale = 1'b1;
    m_lat = -1;
    n_checks++;
    if (bus.core_ready !== 1'b1) $display("FAIL to_stale_setup: got %b expected 1", bus.core_ready);
    else n_pass++;
    issue(OP_MUL, 64'd7, 64'd9);
    wait_rsp(300, lat, starts);
    n_checks++;
    if (lat !== TB_TIMEOUT + 2) $display("FAIL to_latency: got %0d expected %0d", lat, TB_TIMEOUT + 2);
    else n_pass++;
    n_checks++;
    if (bus.rsp_timeout !== 1'b1 || bus.rsp_hi !== 64'd0 || bus.rsp_lo !== 64'd0)
      $display("FAIL to_data: got to=%b hi=%0h lo=%0h expected to=1 hi=0 lo=0",
               bus.rsp_timeout, bus.rsp_hi, bus.rsp_lo);
    else n_pass++;
    take_rsp();
    n_checks++;
    if (bus.rsp_timeout !== 1'b0) $display("FAIL to_clear: got %b expected 0", bus.rsp_timeout);
    else n_pass++;
  endtask

  task automatic test_capture_at_limit();
    int lat, starts;
    m_stale = 1'b0;
    m_lat = TB_TIMEOUT;
    m_result = 129'hABCD;
    issue(OP_MUL, 64'd11, 64'd13);
    wait_rsp(300, lat, starts);
    n_checks++;
    if (lat !== TB_TIMEOUT + 2) $display("FAIL lim_latency: got %0d expected %0d", lat, TB_TIMEOUT + 2);
    else n_pass++;
    n_checks++;
    if (bus.rsp_timeout !== 1'b0 || bus.rsp_lo !== 64'hABCD || bus.rsp_hi !== 64'd0)
      $display("FAIL lim_capture_wins: got to=%b hi=%0h lo=%0h expected to=0 hi=0 lo=abcd",
               bus.rsp_timeout, bus.rsp_hi, bus.rsp_lo);
    else n_pass++;
    take_rsp();
  endtask

  task automatic test_back_to_back();
    int lat, starts;
    int bad;
    m_stale = 1'b0;
    m_lat = 3;
    m_result = {1'b0, 64'h1111, 64'h2222};
    issue(OP_MUL, 64'hAA, 64'hBB);
    wait_rsp(50, lat, starts);
    n_checks++;
    if (lat !== 5) $display("FAIL bp_latency: got %0d expected 5", lat);
    else n_pass++;
    bus.req_valid = 1'b1;
    bus.req_op = OP_DIV;
    bus.req_a = 64'hCC;
    bus.req_b = 64'hDD;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_hi !== 64'h1111 || bus.rsp_lo !== 64'h2222 ||
          bus.req_ready !== 1'b0 || bus.core_a !== 64'hAA) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
    else n_pass++;
    take_rsp();
    n_checks++;
    if (state !== IDLE || bus.req_ready !== 1'b1 || bus.core_a !== 64'hAA)
      $display("FAIL bp_bubble: got state=%0d ready=%b a=%0h expected state=0 ready=1 a=aa",
               state, bus.req_ready, bus.core_a);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_checks++;
    if (state !== ISSUE || bus.core_a !== 64'hCC || bus.core_b !== 64'hDD || bus.core_m_d !== OP_DIV)
      $display("FAIL bp_next_accept: got state=%0d a=%0h b=%0h md=%b expected state=1 a=cc b=dd md=1",
               state, bus.core_a, bus.core_b, bus.core_m_d);
    else n_pass++;
    wait_rsp(50, lat, starts);
    n_checks++;
    if (lat !== 5) $display("FAIL b2b_latency: got %0d expected 5", lat);
    else n_pass++;
    take_rsp();
  endtask

  task automatic test_async_reset();
    int lat, starts;
    int seen;
    m_stale = 1'b0;
    m_lat = 50;
    m_result = 129'd99;
    issue(OP_MUL, 64'h55, 64'h66);
    repeat (4) @(negedge clk);
    n_checks++;
    if (state !== WAIT) $display("FAIL rst_pre_state: got %0d expected %0d", state, WAIT);
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.req_ready, bus.core_start, bus.core_m_d, bus.rsp_valid, bus.rsp_dz, bus.rsp_timeout} !== 6'b0 ||
        {bus.core_a, bus.core_b, bus.rsp_hi, bus.rsp_lo} !== '0)
      $display("FAIL rst_async_outputs: got a=%0h b=%0h ready=%b valid=%b expected all 0",
               bus.core_a, bus.core_b, bus.req_ready, bus.rsp_valid);
    else n_pass++;
    n_checks++;
    if (state !== IDLE) $display("FAIL rst_async_state: got %0d expected %0d", state, IDLE);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || bus.core_start !== 1'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) $display("FAIL rst_no_rsp: got %0d active cycles expected 0", seen);
    else n_pass++;
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL rst_ready_after: got %b expected 1", bus.req_ready);
    else n_pass++;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_multiply();
    test_divide();
    test_div_zero();
    test_timeout();
    test_capture_at_limit();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
